flags_setter: RTL and testbench



---
 rtl/flags_setter.sv | 83 ++++++++
 tb/tb_flags_setter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/flags_setter.sv
// Status-flag register (N, Z, C, V) for the 12-bit accumulator datapath.
// Flags load from the ALU operation on an AC_update edge and hold otherwise.
module flags_setter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AC_update,
    input  logic [3:0]  opcode,
    input  logic [11:0] op1,
    input  logic [11:0] op2,
    input  logic [11:0] AC_result,
    output logic        N,
    output logic        Z,
    output logic        C,
    output logic        V
);

    localparam int DATA_W = 12;

    localparam logic [3:0] OPC_ADD = 4'b1001;
    localparam logic [3:0] OPC_SUB = 4'b1010;
    localparam logic [3:0] OPC_CMP = 4'b0100;

    // Flag vector packing order is {N, Z, C, V} throughout.
    function automatic logic [3:0] add_flags(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] res;
        logic              ovf;
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DATA_W-1:0];
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        return {res[DATA_W-1], (res == '0), sum[DATA_W], ovf};
    endfunction

    // Carry out of the two's-complement subtraction means no borrow.
    function automatic logic [3:0] sub_flags(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0]   diff;
        logic [DATA_W-1:0] res;
        logic              ovf;
        diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        res  = diff[DATA_W-1:0];
        ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        return {res[DATA_W-1], (res == '0), diff[DATA_W], ovf};
    endfunction

    logic signed [DATA_W-1:0] op1_s;
    logic signed [DATA_W-1:0] op2_s;
    logic [3:0]               flags_q;
    logic [3:0]               flags_d;

    assign op1_s = op1;
    assign op2_s = op2;

    always_comb begin
        flags_d = flags_q;
        unique case (opcode)
            OPC_ADD: flags_d = add_flags(op1_s, op2_s);
            OPC_SUB,
            OPC_CMP: flags_d = sub_flags(op1_s, op2_s);
            // Non-arithmetic writes only refresh N/Z from the accumulator value.
            default: flags_d = {AC_result[DATA_W-1], (AC_result == '0), flags_q[1:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (AC_update) begin
            flags_q <= flags_d;
        end
    end

    assign N = flags_q[3];
    assign Z = flags_q[2];
    assign C = flags_q[1];
    assign V = flags_q[0];

endmodule

// File: tb/tb_flags_setter.sv
// Bench for flags_setter: directed vector table followed by randomized
// traffic checked against an integer-arithmetic reference model.
module tb_flags_setter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AC_update;
    logic [3:0]  opcode;
    logic [11:0] op1;
    logic [11:0] op2;
    logic [11:0] AC_result;
    logic        N, Z, C, V;

    int checks = 0;
    int errors = 0;

    flags_setter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AC_update (AC_update),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .AC_result (AC_result),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        upd;
        logic [3:0]  opc;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] r;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic u, input logic [3:0] o,
                                input logic [11:0] a, input logic [11:0] b,
                                input logic [11:0] r, input logic [3:0] e);
        vec_t v;
        v.rst_n = rn; v.upd = u; v.opc = o; v.a = a; v.b = b; v.r = r; v.exp = e;
        return v;
    endfunction

    function automatic int to_signed(input int x);
        return (x >= 2048) ? x - 4096 : x;
    endfunction

    // Reference model from the arithmetic definition of the flags; returns {N,Z,C,V}.
    function automatic logic [3:0] model(input logic [3:0] prev, input logic rn,
                                         input logic u, input logic [3:0] o,
                                         input int a, input int b, input int r);
        int res, sres;
        logic n, z, c, v;
        if (!rn) return 4'b0000;
        if (!u) return prev;
        if (o == 4'd9) begin
            res  = a + b;
            c    = (res >= 4096);
            res  = res % 4096;
            sres = to_signed(a) + to_signed(b);
            v    = (sres > 2047) || (sres < -2048);
        end else if (o == 4'd10 || o == 4'd4) begin
            c    = (a >= b);
            res  = (a - b + 4096) % 4096;
            sres = to_signed(a) - to_signed(b);
            v    = (sres > 2047) || (sres < -2048);
        end else begin
            res = r;
            c   = prev[1];
            v   = prev[0];
        end
        n = (res >= 2048);
        z = (res == 0);
        return {n, z, c, v};
    endfunction

    task automatic apply_and_check(input vec_t v, input string tag, input int idx);
        rst_n = v.rst_n; AC_update = v.upd; opcode = v.opc;
        op1 = v.a; op2 = v.b; AC_result = v.r;
        @(posedge clk);
        #1;
        checks++;
        if ({N, Z, C, V} !== v.exp) begin
            errors++;
            $display("FAIL %s%0d NZCV got %b expected %b (opc=%b op1=%h op2=%h res=%h)",
                     tag, idx, {N, Z, C, V}, v.exp, v.opc, v.a, v.b, v.r);
        end
    endtask

    initial begin
        logic [3:0] mflags;
        vec_t       rv;
        logic [3:0] opc_pick[6];

        rst_n = 1'b0; AC_update = 1'b0; opcode = '0;
        op1 = '0; op2 = '0; AC_result = '0;

        vecs.push_back(mk(0, 0, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 1, 4'b1001, 12'hFFF, 12'h001, 12'h000, 4'b0110));
        vecs.push_back(mk(1, 0, 4'b1010, 12'h123, 12'h456, 12'h800, 4'b0110));
        vecs.push_back(mk(1, 1, 4'b1010, 12'h005, 12'h002, 12'h003, 4'b0010));
        vecs.push_back(mk(1, 1, 4'b1001, 12'h7FF, 12'h001, 12'h800, 4'b1001));
        vecs.push_back(mk(1, 1, 4'b1010, 12'h800, 12'h001, 12'h7FF, 4'b0011));
        // Other opcode keeps C=1,V=1 from the overflowing SUB.
        vecs.push_back(mk(1, 1, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0111));
        vecs.push_back(mk(1, 1, 4'b0100, 12'h005, 12'h002, 12'hFFF, 4'b0010));
        vecs.push_back(mk(1, 1, 4'b0100, 12'h123, 12'h123, 12'h555, 4'b0110));
        vecs.push_back(mk(1, 1, 4'b0100, 12'h001, 12'h002, 12'h000, 4'b1000));
        vecs.push_back(mk(1, 1, 4'b0000, 12'h000, 12'h000, 12'h000, 4'b0100));
        vecs.push_back(mk(1, 1, 4'b0100, 12'h005, 12'h002, 12'h000, 4'b0010));
        vecs.push_back(mk(1, 1, 4'b0111, 12'h005, 12'h002, 12'h800, 4'b1010));
        vecs.push_back(mk(1, 1, 4'b1010, 12'h000, 12'h001, 12'h000, 4'b1000));
        // Back-to-back updates, then reset overriding a pending update.
        vecs.push_back(mk(1, 1, 4'b1001, 12'h001, 12'h001, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 1, 4'b1001, 12'hFFF, 12'hFFF, 12'h000, 4'b1010));
        vecs.push_back(mk(0, 1, 4'b1001, 12'hFFF, 12'h001, 12'h000, 4'b0000));
        vecs.push_back(mk(1, 1, 4'b1001, 12'hFFF, 12'h001, 12'h000, 4'b0110));

        foreach (vecs[i]) apply_and_check(vecs[i], "vec", i);

        // Randomized phase; current flags are known from the last directed vector.
        mflags = vecs[vecs.size()-1].exp;
        opc_pick[0] = 4'b1001; opc_pick[1] = 4'b1010; opc_pick[2] = 4'b0100;
        opc_pick[3] = 4'b1001; opc_pick[4] = 4'b1010; opc_pick[5] = 4'b0100;
        for (int i = 0; i < 400; i++) begin
            rv.rst_n = ($urandom_range(0, 19) != 0);
            rv.upd   = ($urandom_range(0, 3) != 0);
            rv.opc   = ($urandom_range(0, 1) == 0) ? opc_pick[$urandom_range(0, 5)]
                                                   : 4'($urandom_range(0, 15));
            rv.a     = 12'($urandom_range(0, 4095));
            rv.b     = ($urandom_range(0, 7) == 0) ? rv.a : 12'($urandom_range(0, 4095));
            rv.r     = ($urandom_range(0, 5) == 0) ? 12'h000 : 12'($urandom_range(0, 4095));
            mflags   = model(mflags, rv.rst_n, rv.upd, rv.opc,
                             int'(rv.a), int'(rv.b), int'(rv.r));
            rv.exp   = mflags;
            apply_and_check(rv, "rnd", i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
